// File: rtl/cdc_lib_pkg.sv
// Shared definitions for the CDC / FIFO library: FIFO pointer constants,
// the write-arbiter FSM encoding and its watchdog width.
package cdc_lib;

  // FIFO pointer geometry used by the FIFO read/write controllers.
  localparam int FIFO_ADDR_W = 4;
  localparam int FIFO_PTR_W  = FIFO_ADDR_W + 1;
  localparam int FIFO_DEPTH  = 1 << FIFO_ADDR_W;

  // Write-arbiter packet lock watchdog width.
  localparam int WDOG_W = 8;

  // Write-arbiter states: IDLE arbitrates per beat, LOCK pins the owner
  // until the last beat of its packet or a watchdog abort.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin search: first asserted request at or after (ptr+1) mod N,
// wrapping around. Purely combinational.
module rr_pick
  import cdc_lib::*;
#(
  parameter int P_NUM_REQ = 4,
  parameter int P_IDX_MSB = 1
) (
  input  logic [P_NUM_REQ-1:0] i_req,
  input  logic [P_IDX_MSB:0]   i_ptr,
  output logic [P_IDX_MSB:0]   o_idx,
  output logic                 o_found
);

  localparam int IDX_W = P_IDX_MSB + 1;

  // Walk the requesters starting just after the pointer; keep the first hit.
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand    = '0;
    o_idx   = '0;
    o_found = 1'b0;
    for (int off = 1; off <= P_NUM_REQ; off++) begin
      cand = IDX_W'((int'(i_ptr) + off) % P_NUM_REQ);
      if (!o_found && i_req[cand]) begin
        o_found = 1'b1;
        o_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-aware write arbiter in front of a FIFO write controller.
// Beats are granted round-robin while idle; a packet with more than one
// beat locks the owner until its last beat, guarded by a stall watchdog.
module fifo_wr_arbiter
  import cdc_lib::*;
#(
  parameter int P_NUM_REQ  = 4,
  parameter int P_DATA_MSB = 31,
  parameter int P_IDX_MSB  = 1,
  parameter int P_TMO      = 15
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic [P_NUM_REQ-1:0]                 i_req_valid,
  input  logic [P_NUM_REQ-1:0]                 i_req_last,
  input  logic [P_NUM_REQ*(P_DATA_MSB+1)-1:0]  i_req_data,
  output logic [P_NUM_REQ-1:0]                 o_req_ready,
  input  logic                                 i_full,
  output logic                                 o_wr_inc,
  output logic [P_DATA_MSB:0]                  o_wr_data,
  output logic [P_IDX_MSB:0]                   o_grant_idx,
  output logic                                 o_busy,
  output logic                                 o_abort
);

  localparam int                DATA_W   = P_DATA_MSB + 1;
  localparam int                IDX_W    = P_IDX_MSB + 1;
  localparam logic [WDOG_W-1:0] TMO_LAST = WDOG_W'(P_TMO - 1);
  localparam logic [IDX_W-1:0]  PTR_INIT = IDX_W'(P_NUM_REQ - 1);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              run_q;

  logic [IDX_W-1:0]  pick_idx;
  logic              pick_found;
  logic [IDX_W-1:0]  owner;
  logic              owner_valid;
  logic              owner_last;
  logic              idle_tick;
  logic              xfer;
  logic              abort;

  logic [DATA_W-1:0] data_slice [P_NUM_REQ];

  for (genvar g = 0; g < P_NUM_REQ; g++) begin : g_slice
    assign data_slice[g] = i_req_data[g*DATA_W +: DATA_W];
  end

  rr_pick #(
    .P_NUM_REQ (P_NUM_REQ),
    .P_IDX_MSB (P_IDX_MSB)
  ) u_rr_pick (
    .i_req   (i_req_valid),
    .i_ptr   (rr_ptr_q),
    .o_idx   (pick_idx),
    .o_found (pick_found)
  );

  // Current owner: the locked requester, else the round-robin pick, else
  // the previous grant; forced to 0 while reset is held.
  always_comb begin
    owner       = owner_q;
    owner_valid = 1'b0;
    if (!i_rst_n) begin
      owner = '0;
    end else if (state_q == ST_LOCK) begin
      owner_valid = i_req_valid[owner_q];
    end else if (pick_found) begin
      owner       = pick_idx;
      owner_valid = 1'b1;
    end
  end

  // Transfer and watchdog qualifiers; run_q keeps everything quiet during
  // reset and in the first cycle after it is released.
  always_comb begin
    owner_last = i_req_last[owner];
    xfer       = run_q && owner_valid && !i_full;
    idle_tick  = run_q && (state_q == ST_LOCK) && !owner_valid && !i_full;
    abort      = idle_tick && (wdog_q == TMO_LAST);
  end

  // Next-state logic for the lock FSM, round-robin pointer and watchdog.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    wdog_d   = wdog_q;
    owner_d  = owner;
    case (state_q)
      ST_IDLE: begin
        wdog_d = '0;
        if (xfer) begin
          if (owner_last) begin
            rr_ptr_d = owner;
          end else begin
            state_d = ST_LOCK;
          end
        end
      end
      ST_LOCK: begin
        if (xfer) begin
          wdog_d = '0;
          if (owner_last) begin
            state_d  = ST_IDLE;
            rr_ptr_d = owner;
          end
        end else if (abort) begin
          state_d  = ST_IDLE;
          rr_ptr_d = owner;
          wdog_d   = '0;
        end else if (idle_tick) begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        wdog_d  = '0;
      end
    endcase
  end

  // State registers; reset drops any lock silently and points rr at the
  // last requester so requester 0 wins first.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= PTR_INIT;
      owner_q  <= '0;
      wdog_q   <= '0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      wdog_q   <= wdog_d;
      run_q    <= 1'b1;
    end
  end

  // Output drive: one-hot ready for the owner on a transfer, data muxed
  // from the owner's slice.
  always_comb begin
    o_wr_inc    = xfer;
    o_req_ready = xfer ? (P_NUM_REQ'(1) << owner) : '0;
    o_wr_data   = data_slice[owner];
    o_grant_idx = owner;
    o_busy      = (state_q == ST_LOCK);
    o_abort     = abort;
  end

endmodule
